pi_sample_accumulator: RTL and testbench
========================================

Name: pi_sample_accumulator

Overview:
- Consumes the per-sample inside/outside verdict from the circle checker, paired with the point coordinates that produced it.
- Counts valid samples and inside hits over a run of 2^LOG2_SAMPLES samples, then latches a fixed-point pi estimate for the VGA readout logic.
- Runs are started and restarted by a start strobe. Live counts are exposed while a run is in progress.

Parameters:
- LOG2_SAMPLES, 20, log2 of the samples per run; legal range 2..24.
- SQUARE_SIDE, 480, exclusive upper bound on each coordinate; a sample with x or y >= SQUARE_SIDE is discarded.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle strobe; clears the counters and begins a run
- sample_valid  input  1  sample qualifier for x_coord, y_coord and is_inside in this cycle
- x_coord  input  10  sample x coordinate, as applied to the checker
- y_coord  input  10  sample y coordinate, as applied to the checker
- is_inside  input  1  checker verdict for the same-cycle coordinates (combinational)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a run completes
- result_valid  output  1  high from completion until the next start or reset
- total_count  output  LOG2_SAMPLES+1  live count of accepted samples
- inside_count  output  LOG2_SAMPLES+1  live count of accepted inside samples
- pi_estimate  output  LOG2_SAMPLES+1  latched result, unsigned fixed point with LOG2_SAMPLES-2 fractional bits

Behaviour:
- Reset (synchronous, any state): state=IDLE; all counters, pi_estimate, busy, done and result_valid go to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> clear both counters, clear result_valid, go to RUN.
  - Samples presented in IDLE are ignored.
- RUN:
  - busy=1.
  - A sample is accepted when sample_valid=1 and x_coord<SQUARE_SIDE and y_coord<SQUARE_SIDE.
  - On an accepted sample: total_count+1 at the next edge; inside_count+1 as well if is_inside=1.
  - Rejected samples change nothing.
  - When an accepted sample brings total_count to 2^LOG2_SAMPLES (next-value compare): take that final sample's count update, go to DONE.
- DONE (exactly one cycle):
  - done=1.
  - pi_estimate <= inside_count (the final value, including the last sample).
  - result_valid <= 1.
  - Next state IDLE. Inputs are ignored in this cycle, including start.
- Value relations:
  - pi_estimate equals 4*inside/2^LOG2_SAMPLES, because the raw count carries LOG2_SAMPLES-2 fractional bits.
  - Counter width LOG2_SAMPLES+1 holds 2^LOG2_SAMPLES exactly, so no wrap-around is possible.
  - inside_count <= total_count always.
- start while in RUN: restart. Counters clear, stay in RUN, and the same-cycle sample is dropped. result_valid stays 0.
- start in IDLE with result_valid=1: result_valid clears at the next edge. pi_estimate keeps its old value until the next DONE.
- Latency: one cycle from an accepted sample to the count update. done asserts in the cycle after the final accepted sample's edge.
- total_count and inside_count hold their final values in IDLE after completion.

Test Plan:
- Reset, then idle 5 cycles with sample_valid=1 -> busy=0, result_valid=0, all counts 0.
- LOG2_SAMPLES=4; start; 16 valid in-range samples, 13 with is_inside=1 -> done pulses once, pi_estimate=13 (3.25), total_count=16, result_valid=1.
- LOG2_SAMPLES=4; mix 16 accepted samples with x=480, y=479 and x=1023, y=0 (rejected) -> rejects leave the counts unchanged; done only after the 16th accepted sample.
- Gapped input: sample_valid toggling every cycle, 16 accepted samples with 16 inside -> pi_estimate=16 (4.00); samples presented in the DONE/IDLE cycles are ignored.
- Restart: start, 7 accepted samples, start again (with a valid sample in that cycle) -> counters at 0, the dropped sample not counted; a further 16 samples are needed before done.
- Reset asserted mid-run with total_count=9 -> next cycle all outputs 0, state IDLE; a following start plus 16 samples completes normally.

Source files
------------

// File: rtl/pi_sample_accumulator.sv
// Monte Carlo pi accumulator: counts accepted samples and inside hits
// over a run of 2^LOG2_SAMPLES samples, then latches the pi estimate.
module pi_sample_accumulator #(
    parameter int LOG2_SAMPLES = 20,
    parameter int SQUARE_SIDE  = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  sample_valid,
    input  logic [9:0]            x_coord,
    input  logic [9:0]            y_coord,
    input  logic                  is_inside,
    output logic                  busy,
    output logic                  done,
    output logic                  result_valid,
    output logic [LOG2_SAMPLES:0] total_count,
    output logic [LOG2_SAMPLES:0] inside_count,
    output logic [LOG2_SAMPLES:0] pi_estimate
);

    localparam int W = LOG2_SAMPLES + 1;

    // Run length as a counter value; the counter is one bit wider so it fits
    localparam logic [W-1:0] FULL = {1'b1, {LOG2_SAMPLES{1'b0}}};

    // Widened bound so a side of 1024 still compares correctly
    localparam logic [10:0] SIDE = 11'(SQUARE_SIDE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           rv_q, rv_d;
    logic [W-1:0]   total_q, total_d;
    logic [W-1:0]   inside_q, inside_d;
    logic [W-1:0]   pi_q, pi_d;

    logic           accept;
    logic [W-1:0]   total_inc;

    assign accept = sample_valid
                  && ({1'b0, x_coord} < SIDE)
                  && ({1'b0, y_coord} < SIDE);

    assign total_inc = total_q + W'(1);

    // Next-state and next-output logic for the run controller
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rv_d     = rv_q;
        total_d  = total_q;
        inside_d = inside_q;
        pi_d     = pi_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    rv_d     = 1'b0;
                    total_d  = '0;
                    inside_d = '0;
                end
            end
            RUN: begin
                if (start) begin
                    total_d  = '0;
                    inside_d = '0;
                end else if (accept) begin
                    total_d = total_inc;
                    if (is_inside) begin
                        inside_d = inside_q + W'(1);
                    end
                    if (total_inc == FULL) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                pi_d    = inside_q;
                rv_d    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rv_q     <= 1'b0;
            total_q  <= '0;
            inside_q <= '0;
            pi_q     <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rv_q     <= rv_d;
            total_q  <= total_d;
            inside_q <= inside_d;
            pi_q     <= pi_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = rv_q;
    assign total_count  = total_q;
    assign inside_count = inside_q;
    assign pi_estimate  = pi_q;

endmodule

// File: tb/tb_pi_sample_accumulator.sv
// Bench for pi_sample_accumulator: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the run rules.
module tb_pi_sample_accumulator;

    localparam int L = 4;
    localparam int W = L + 1;
    localparam int N = 1 << L;
    localparam int SIDE = 480;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sample_valid = 1'b0;
    logic [9:0]   x_coord = '0;
    logic [9:0]   y_coord = '0;
    logic         is_inside = 1'b0;
    logic         busy;
    logic         done;
    logic         result_valid;
    logic [W-1:0] total_count;
    logic [W-1:0] inside_count;
    logic [W-1:0] pi_estimate;

    pi_sample_accumulator #(
        .LOG2_SAMPLES(L),
        .SQUARE_SIDE (SIDE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .sample_valid(sample_valid),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .is_inside   (is_inside),
        .busy        (busy),
        .done        (done),
        .result_valid(result_valid),
        .total_count (total_count),
        .inside_count(inside_count),
        .pi_estimate (pi_estimate)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    bit chk_en = 0;

    // Reference: a run is "active" while counting, "finishing" for the
    // single cycle after the last sample lands.
    bit m_active = 0;
    bit m_finishing = 0;
    bit m_rv = 0;
    int m_tot = 0;
    int m_ins = 0;
    int m_pi = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_square(logic [9:0] x, logic [9:0] y);
        return (int'(x) < SIDE) && (int'(y) < SIDE);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_active = 0;
                m_finishing = 0;
                m_rv = 0;
                m_tot = 0;
                m_ins = 0;
                m_pi = 0;
            end else if (m_finishing) begin
                m_pi = m_ins;
                m_rv = 1;
                m_finishing = 0;
            end else if (m_active) begin
                if (start) begin
                    m_tot = 0;
                    m_ins = 0;
                end else if (sample_valid && in_square(x_coord, y_coord)) begin
                    m_tot++;
                    if (is_inside) m_ins++;
                    if (m_tot == N) begin
                        m_active = 0;
                        m_finishing = 1;
                    end
                end
            end else if (start) begin
                m_tot = 0;
                m_ins = 0;
                m_rv = 0;
                m_active = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy", int'(busy), int'(m_active));
                check("done", int'(done), int'(m_finishing));
                check("result_valid", int'(result_valid), int'(m_rv));
                check("total_count", int'(total_count), m_tot);
                check("inside_count", int'(inside_count), m_ins);
                check("pi_estimate", int'(pi_estimate), m_pi);
                check("inside_le_total",
                      int'(inside_count <= total_count), 1);
                if (done) done_seen++;
            end
        end
    end

    task automatic cyc(bit rst, bit st, bit v, int x, int y, bit ins);
        @(negedge clk);
        reset = rst;
        start = st;
        sample_valid = v;
        x_coord = 10'(x);
        y_coord = 10'(y);
        is_inside = ins;
    endtask

    function automatic int rin();
        return int'($urandom_range(0, SIDE - 1));
    endfunction

    task automatic acc(bit ins);
        cyc(0, 0, 1, rin(), rin(), ins);
    endtask

    task automatic rej();
        int k;
        k = int'($urandom_range(0, 2));
        if (k == 0) cyc(0, 0, 1, 480, 479, 1'($urandom));
        else if (k == 1) cyc(0, 0, 1, 1023, 0, 1'($urandom));
        else cyc(0, 0, 1, rin(), int'($urandom_range(480, 1023)), 1'($urandom));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        cyc(1, 0, 1, rin(), rin(), 1);
        cyc(1, 0, 1, rin(), rin(), 1);
        chk_en = 1;

        // Idle with samples present: nothing counts
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, rin(), rin(), 1'($urandom));
        check("idle_busy", int'(busy), 0);
        check("idle_rv", int'(result_valid), 0);
        check("idle_total", int'(total_count), 0);
        check("idle_inside", int'(inside_count), 0);

        // 16 samples, 13 inside
        cyc(0, 1, 1, rin(), rin(), 1);
        for (int i = 0; i < N; i++) acc(!(i == 0 || i == 7 || i == 15));
        idle(3);
        check("run1_pi", int'(pi_estimate), 13);
        check("run1_total", int'(total_count), 16);
        check("run1_inside", int'(inside_count), 13);
        check("run1_rv", int'(result_valid), 1);
        check("run1_done_pulses", done_seen, 1);

        // Rejected coordinates mixed in
        cyc(0, 1, 0, 0, 0, 0);
        acc(1);
        check("restart_rv_clear", int'(result_valid), 0);
        check("pi_held", int'(pi_estimate), 13);
        n = 1;
        while (n < N - 1) begin
            if ($urandom_range(0, 2) == 0) rej();
            else begin
                acc(1'($urandom));
                n++;
            end
        end
        rej();
        rej();
        idle(1);
        check("rej_total15", int'(total_count), 15);
        check("rej_busy", int'(busy), 1);
        check("rej_no_done", done_seen, 1);
        acc(1);
        idle(3);
        check("rej_done_pulses", done_seen, 2);
        check("rej_total", int'(total_count), 16);

        // Gapped samples, all inside, then samples during DONE/IDLE
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2 * N; i++) cyc(0, 0, i % 2, rin(), rin(), 1);
        for (int i = 0; i < 4; i++) acc(1);
        check("gap_pi", int'(pi_estimate), 16);
        check("gap_total", int'(total_count), 16);
        check("gap_inside", int'(inside_count), 16);
        check("gap_done_pulses", done_seen, 3);

        // Restart mid-run with a sample in the start cycle
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) acc(1);
        cyc(0, 1, 1, rin(), rin(), 1);
        acc(1);
        check("rst_cleared", int'(total_count), 0);
        check("rst_busy", int'(busy), 1);
        for (int i = 0; i < N - 2; i++) acc(1'($urandom));
        idle(1);
        check("rst_total15", int'(total_count), 15);
        check("rst_no_done", done_seen, 3);
        acc(0);
        idle(3);
        check("rst_done_pulses", done_seen, 4);

        // Reset in the middle of a run
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) acc(1);
        idle(1);
        check("mid_total9", int'(total_count), 9);
        cyc(1, 0, 1, rin(), rin(), 1);
        cyc(0, 0, 0, 0, 0, 0);
        check("rst_all_busy", int'(busy), 0);
        check("rst_all_total", int'(total_count), 0);
        check("rst_all_pi", int'(pi_estimate), 0);
        check("rst_all_rv", int'(result_valid), 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) acc(1);
        idle(3);
        check("post_rst_done", done_seen, 5);
        check("post_rst_rv", int'(result_valid), 1);

        // Random traffic, including starts during DONE and resets
        for (int i = 0; i < 600; i++) begin
            bit in_range;
            in_range = ($urandom_range(0, 5) != 0);
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 3) != 0),
                in_range ? rin() : int'($urandom_range(0, 1023)),
                in_range ? rin() : int'($urandom_range(0, 1023)),
                1'($urandom));
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
